// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8:1 select-driven mux.
// Drives a registered 3-bit select and a one-hot grant, and holds them for the
// owner's transfer. Ownership is revoked after MAX_HOLD valid cycles so that no
// requester can starve the others.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] select,
    output logic [7:0] grant,
    output logic       valid,
    output logic       expired
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [0:0]        state_q,    state_d;
    logic [2:0]        ptr_q,      ptr_d;
    logic [2:0]        owner_q,    owner_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]        select_q,   select_d;
    logic [7:0]        grant_q,    grant_d;
    logic              valid_q,    valid_d;
    logic              expired_q,  expired_d;

    logic       found;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       owner_req;
    logic       at_limit;
    logic       release_now;
    logic       timeout;

    // Rotating priority search: first requester at or after ptr, wrapping mod 8.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Release conditions for the current owner; timeout only when the hold
    // limit is the sole reason for giving up the mux.
    always_comb begin
        owner_req   = req[owner_q];
        at_limit    = (hold_cnt_q == HOLD_LAST);
        release_now = done | ~owner_req | at_limit;
        timeout     = at_limit & ~done & owner_req;
    end

    // Next-state logic for the IDLE/BUSY controller and its registered outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        select_d   = select_q;
        grant_d    = '0;
        valid_d    = 1'b0;
        expired_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_BUSY;
                    owner_d    = winner;
                    select_d   = winner;
                    grant_d    = 8'b1 << winner;
                    valid_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (release_now) begin
                    state_d   = ST_IDLE;
                    ptr_d     = owner_q + 3'd1;
                    expired_d = timeout;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    grant_d    = grant_q;
                    valid_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            select_q   <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            select_q   <= select_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            expired_q  <= expired_d;
        end
    end

    assign select  = select_q;
    assign grant   = grant_q;
    assign valid   = valid_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, single owner, fairness rotation,
// hold-limit expiry, request drop and coincident release conditions.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n, reset2_n;
    logic [7:0] req, req2;
    logic       done, done2;
    logic [2:0] select, select2;
    logic [7:0] grant, grant2;
    logic       valid, valid2;
    logic       expired, expired2;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .done(done),
        .select(select), .grant(grant), .valid(valid), .expired(expired)
    );

    mux_rr_arbiter #(.MAX_HOLD(2), .HOLD_W(4)) dut2 (
        .clk(clk), .reset_n(reset2_n), .req(req2), .done(done2),
        .select(select2), .grant(grant2), .valid(valid2), .expired(expired2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    // Structural invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        chk("inv_grant", {24'd0, grant}, valid ? (32'd1 << select) : 32'd0);
        chk("inv_exp",   {31'd0, expired & valid}, 32'd0);
        chk("inv_grant2", {24'd0, grant2}, valid2 ? (32'd1 << select2) : 32'd0);
        chk("inv_exp2",  {31'd0, expired2 & valid2}, 32'd0);
    end

    initial begin
        reset_n  = 1'b0;
        reset2_n = 1'b0;
        req      = 8'h00;
        req2     = 8'h00;
        done     = 1'b0;
        done2    = 1'b0;

        // Reset state
        step();
        chk("rst_valid",   {31'd0, valid},   32'd0);
        chk("rst_grant",   {24'd0, grant},   32'd0);
        chk("rst_select",  {29'd0, select},  32'd0);
        chk("rst_expired", {31'd0, expired}, 32'd0);
        reset_n = 1'b1;
        step();
        chk("idle_valid", {31'd0, valid}, 32'd0);

        // Reset in the middle of BUSY
        req = 8'h04;
        step();
        chk("r_grant",  {24'd0, grant},  32'h04);
        chk("r_select", {29'd0, select}, 32'd2);
        chk("r_valid",  {31'd0, valid},  32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_async_valid",  {31'd0, valid},   32'd0);
        chk("r_async_grant",  {24'd0, grant},   32'd0);
        chk("r_async_select", {29'd0, select},  32'd0);
        chk("r_async_exp",    {31'd0, expired}, 32'd0);
        req = 8'h10;
        reset_n = 1'b1;
        step();
        chk("r_regrant",  {24'd0, grant},  32'h10);
        chk("r_reselect", {29'd0, select}, 32'd4);
        done = 1'b1;
        step();
        chk("r_rel_valid", {31'd0, valid}, 32'd0);
        done = 1'b0;
        req  = 8'h00;
        step();

        // Single owner, done on third valid cycle
        req = 8'h20;
        step();
        chk("s_sel1",   {29'd0, select}, 32'd5);
        chk("s_grant1", {24'd0, grant},  32'h20);
        chk("s_valid1", {31'd0, valid},  32'd1);
        step();
        chk("s_valid2", {31'd0, valid},  32'd1);
        step();
        chk("s_valid3", {31'd0, valid},  32'd1);
        done = 1'b1;
        step();
        chk("s_idle_valid", {31'd0, valid},   32'd0);
        chk("s_idle_grant", {24'd0, grant},   32'd0);
        chk("s_idle_exp",   {31'd0, expired}, 32'd0);
        chk("s_idle_sel",   {29'd0, select},  32'd5);
        done = 1'b0;
        step();
        chk("s_regrant", {24'd0, grant}, 32'h20);
        chk("s_resel",   {29'd0, select}, 32'd5);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;

        // Fairness: all requesting, done every BUSY cycle
        do_reset();
        req  = 8'hFF;
        done = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("f_valid", {31'd0, valid},  32'd1);
            chk("f_sel",   {29'd0, select}, 32'(k % 8));
            chk("f_grant", {24'd0, grant},  32'd1 << (k % 8));
            step();
            chk("f_gap", {31'd0, valid}, 32'd0);
        end
        req  = 8'h00;
        done = 1'b0;

        // Timeout after MAX_HOLD=4 valid cycles
        do_reset();
        req = 8'h04;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t_valid", {31'd0, valid},   32'd1);
            chk("t_sel",   {29'd0, select},  32'd2);
            chk("t_noexp", {31'd0, expired}, 32'd0);
        end
        step();
        chk("t_rel_valid", {31'd0, valid},   32'd0);
        chk("t_expired",   {31'd0, expired}, 32'd1);
        req = 8'h05;
        step();
        chk("t_wrap_sel",   {29'd0, select},  32'd0);
        chk("t_wrap_grant", {24'd0, grant},   32'h01);
        chk("t_exp_clear",  {31'd0, expired}, 32'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;

        // Owner drops its request on the second BUSY cycle
        do_reset();
        req = 8'h40;
        step();
        chk("d_sel", {29'd0, select}, 32'd6);
        step();
        chk("d_valid2", {31'd0, valid}, 32'd1);
        req = 8'h81;
        step();
        chk("d_rel_valid", {31'd0, valid},   32'd0);
        chk("d_rel_exp",   {31'd0, expired}, 32'd0);
        step();
        chk("d_next_sel",   {29'd0, select}, 32'd7);
        chk("d_next_grant", {24'd0, grant},  32'h80);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'h00;

        // Coincident done and hold limit with MAX_HOLD=2
        reset2_n = 1'b1;
        req2 = 8'h01;
        step();
        chk("m_valid1", {31'd0, valid2}, 32'd1);
        chk("m_sel",    {29'd0, select2}, 32'd0);
        step();
        chk("m_valid2", {31'd0, valid2}, 32'd1);
        done2 = 1'b1;
        step();
        chk("m_rel_valid", {31'd0, valid2},   32'd0);
        chk("m_rel_exp",   {31'd0, expired2}, 32'd0);
        done2 = 1'b0;
        step();
        chk("m_regrant", {24'd0, grant2}, 32'h01);
        step();
        step();
        chk("m_pure_exp", {31'd0, expired2}, 32'd1);
        req2 = 8'h00;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
